// File: rtl/multi_dispatch_scoreboard.sv
// Issue-stage scoreboard: in-order dispatch and issue, out-of-order writeback,
// in-order commit. Each instruction's trans_id is the index of its entry.
module multi_dispatch_scoreboard #(
  parameter int unsigned NR_ENTRIES      = 8,
  parameter int unsigned DISPATCH_WIDTH  = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned PAYLOAD_W       = 64,
  parameter int unsigned DATA_W          = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   flush_i,
  input  logic                                   flush_unissued_i,
  input  logic [DISPATCH_WIDTH-1:0]              dispatch_valid_i,
  input  logic [DISPATCH_WIDTH*PAYLOAD_W-1:0]    dispatch_payload_i,
  output logic [DISPATCH_WIDTH-1:0]              dispatch_ready_o,
  output logic                                   issue_valid_o,
  output logic [PAYLOAD_W-1:0]                   issue_payload_o,
  output logic [$clog2(NR_ENTRIES)-1:0]          issue_trans_id_o,
  input  logic                                   issue_ready_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_valid_i,
  input  logic [NR_WB_PORTS*$clog2(NR_ENTRIES)-1:0] wb_trans_id_i,
  input  logic [NR_WB_PORTS*DATA_W-1:0]          wb_data_i,
  input  logic [NR_WB_PORTS-1:0]                 wb_ex_i,
  output logic [NR_COMMIT_PORTS-1:0]             commit_valid_o,
  output logic [NR_COMMIT_PORTS*PAYLOAD_W-1:0]   commit_payload_o,
  output logic [NR_COMMIT_PORTS*DATA_W-1:0]      commit_data_o,
  output logic [NR_COMMIT_PORTS-1:0]             commit_ex_o,
  input  logic [NR_COMMIT_PORTS-1:0]             commit_ack_i,
  output logic                                   full_o,
  output logic [$clog2(NR_ENTRIES+1)-1:0]        count_o
);

  localparam int unsigned TW = $clog2(NR_ENTRIES);
  localparam int unsigned CW = $clog2(NR_ENTRIES + 1);
  localparam logic [CW-1:0] DEPTH = CW'(NR_ENTRIES);

  typedef enum logic [1:0] {
    ST_FREE,
    ST_WAITING,
    ST_ISSUED,
    ST_DONE
  } entry_state_e;

  entry_state_e         state_q   [NR_ENTRIES];
  entry_state_e         state_d   [NR_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_q [NR_ENTRIES];
  logic [PAYLOAD_W-1:0] payload_d [NR_ENTRIES];
  logic [DATA_W-1:0]    data_q    [NR_ENTRIES];
  logic [DATA_W-1:0]    data_d    [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] ex_q, ex_d;

  logic [TW-1:0] head_q, head_d;
  logic [TW-1:0] issue_q, issue_d;
  logic [TW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  logic [CW-1:0]         free_slots;
  logic [TW-1:0]         cidx;
  logic                  chain;
  logic                  issue_fire;
  logic [TW-1:0]         wb_id;
  logic [TW-1:0]         aidx;
  logic [TW-1:0]         didx;
  logic [NR_ENTRIES-1:0] wb_hit;
  logic [CW-1:0]         n_disp;
  logic [CW-1:0]         n_ack;
  logic [CW-1:0]         n_flushed;

  // All outputs depend on registered state only.
  always_comb begin
    free_slots       = DEPTH - count_q;
    full_o           = (count_q == DEPTH);
    count_o          = count_q;
    dispatch_ready_o = '0;
    for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
      dispatch_ready_o[k] = (free_slots > CW'(k));
    end

    issue_valid_o    = (issue_q != tail_q) || (full_o && (state_q[issue_q] == ST_WAITING));
    issue_payload_o  = payload_q[issue_q];
    issue_trans_id_o = issue_q;

    commit_valid_o   = '0;
    commit_payload_o = '0;
    commit_data_o    = '0;
    commit_ex_o      = '0;
    cidx             = '0;
    chain            = 1'b1;
    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      cidx  = head_q + TW'(k);
      chain = chain && (count_q > CW'(k)) && (state_q[cidx] == ST_DONE);
      commit_valid_o[k]                          = chain;
      commit_payload_o[k*PAYLOAD_W +: PAYLOAD_W] = payload_q[cidx];
      commit_data_o[k*DATA_W +: DATA_W]          = data_q[cidx];
      commit_ex_o[k]                             = ex_q[cidx];
    end
  end

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    data_d    = data_q;
    ex_d      = ex_q;
    head_d    = head_q;
    issue_d   = issue_q;
    tail_d    = tail_q;
    count_d   = count_q;
    wb_id     = '0;
    aidx      = '0;
    didx      = '0;
    wb_hit    = '0;
    n_disp    = '0;
    n_ack     = '0;
    n_flushed = '0;

    // Writeback is qualified by the registered state, so a same-cycle issue is not a target.
    for (int unsigned p = 0; p < NR_WB_PORTS; p++) begin
      wb_id = wb_trans_id_i[p*TW +: TW];
      if (wb_valid_i[p] && (state_q[wb_id] == ST_ISSUED) && !wb_hit[wb_id]) begin
        wb_hit[wb_id]  = 1'b1;
        state_d[wb_id] = ST_DONE;
        data_d[wb_id]  = wb_data_i[p*DATA_W +: DATA_W];
        ex_d[wb_id]    = wb_ex_i[p];
      end
    end

    issue_fire = issue_valid_o && issue_ready_i;
    if (issue_fire) begin
      state_d[issue_q] = ST_ISSUED;
      issue_d          = issue_q + 1'b1;
    end

    for (int unsigned k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (commit_ack_i[k]) begin
        aidx          = head_q + TW'(k);
        state_d[aidx] = ST_FREE;
        n_ack         = n_ack + CW'(1);
      end
    end
    head_d = head_q + n_ack[TW-1:0];

    if (flush_unissued_i) begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        if ((state_q[e] == ST_WAITING) && !(issue_fire && (TW'(e) == issue_q))) begin
          state_d[e] = ST_FREE;
          n_flushed  = n_flushed + CW'(1);
        end
      end
      tail_d = issue_d;
    end else begin
      for (int unsigned k = 0; k < DISPATCH_WIDTH; k++) begin
        if (dispatch_valid_i[k] && dispatch_ready_o[k]) begin
          didx            = tail_q + n_disp[TW-1:0];
          state_d[didx]   = ST_WAITING;
          payload_d[didx] = dispatch_payload_i[k*PAYLOAD_W +: PAYLOAD_W];
          n_disp          = n_disp + CW'(1);
        end
      end
      tail_d = tail_q + n_disp[TW-1:0];
    end

    count_d = count_q + n_disp - n_ack - n_flushed;

    if (flush_i) begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        state_d[e] = ST_FREE;
      end
      head_d  = '0;
      issue_d = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned e = 0; e < NR_ENTRIES; e++) begin
        state_q[e] <= ST_FREE;
      end
      head_q  <= '0;
      issue_q <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      issue_q <= issue_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload and result storage is only observed through valid entries; no reset needed.
  always_ff @(posedge clk_i) begin
    payload_q <= payload_d;
    data_q    <= data_d;
    ex_q      <= ex_d;
  end

endmodule

// File: tb/tb_multi_dispatch_scoreboard.sv
// Self-checking bench for multi_dispatch_scoreboard: directed scenarios plus
// randomized traffic against an in-order queue model of the scoreboard.
module tb_multi_dispatch_scoreboard;

  localparam int N  = 8;
  localparam int DW = 2;
  localparam int WP = 4;
  localparam int CP = 2;
  localparam int TW = 3;
  localparam logic [63:0] PBASE = 64'hC0DE_0000_0000_0000;
  localparam logic [63:0] DMASK = 64'h5A5A_A5A5_0F0F_F0F0;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          flush_i;
  logic          flush_unissued_i;
  logic [1:0]    dispatch_valid_i;
  logic [127:0]  dispatch_payload_i;
  logic [1:0]    dispatch_ready_o;
  logic          issue_valid_o;
  logic [63:0]   issue_payload_o;
  logic [2:0]    issue_trans_id_o;
  logic          issue_ready_i;
  logic [3:0]    wb_valid_i;
  logic [11:0]   wb_trans_id_i;
  logic [255:0]  wb_data_i;
  logic [3:0]    wb_ex_i;
  logic [1:0]    commit_valid_o;
  logic [127:0]  commit_payload_o;
  logic [127:0]  commit_data_o;
  logic [1:0]    commit_ex_o;
  logic [1:0]    commit_ack_i;
  logic          full_o;
  logic [3:0]    count_o;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multi_dispatch_scoreboard #(
    .NR_ENTRIES(8), .DISPATCH_WIDTH(2), .NR_WB_PORTS(4),
    .NR_COMMIT_PORTS(2), .PAYLOAD_W(64), .DATA_W(64)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .flush_i(flush_i), .flush_unissued_i(flush_unissued_i),
    .dispatch_valid_i(dispatch_valid_i), .dispatch_payload_i(dispatch_payload_i),
    .dispatch_ready_o(dispatch_ready_o), .issue_valid_o(issue_valid_o),
    .issue_payload_o(issue_payload_o), .issue_trans_id_o(issue_trans_id_o),
    .issue_ready_i(issue_ready_i), .wb_valid_i(wb_valid_i), .wb_trans_id_i(wb_trans_id_i),
    .wb_data_i(wb_data_i), .wb_ex_i(wb_ex_i), .commit_valid_o(commit_valid_o),
    .commit_payload_o(commit_payload_o), .commit_data_o(commit_data_o),
    .commit_ex_o(commit_ex_o), .commit_ack_i(commit_ack_i), .full_o(full_o), .count_o(count_o)
  );

  // Model: program-order queue from the oldest live instruction; st 0=waiting 1=issued 2=done.
  typedef struct {
    logic [63:0] payload;
    logic [63:0] data;
    logic        ex;
    int          st;
  } ment_t;

  ment_t mq[$];
  int    m_head = 0;

  function automatic int m_issue_idx();
    for (int i = 0; i < mq.size(); i++) if (mq[i].st == 0) return i;
    return -1;
  endfunction

  function automatic int m_commit_n();
    int n = 0;
    while (n < CP && n < mq.size() && mq[n].st == 2) n++;
    return n;
  endfunction

  task automatic model_update();
    int pre, ii, nack, id, i;
    logic [N-1:0] hit;
    ment_t e;
    ment_t keep[$];
    pre  = mq.size();
    nack = 0;
    hit  = '0;
    if (!rst_ni || flush_i) begin
      mq.delete();
      m_head = 0;
      return;
    end
    ii = m_issue_idx();
    for (int p = 0; p < WP; p++) begin
      if (wb_valid_i[p]) begin
        id = int'(wb_trans_id_i[p*TW +: TW]);
        i  = (id - m_head + N) % N;
        if (i < pre && mq[i].st == 1 && !hit[i]) begin
          hit[i] = 1'b1;
          e = mq[i]; e.st = 2; e.data = wb_data_i[p*64 +: 64]; e.ex = wb_ex_i[p]; mq[i] = e;
        end
      end
    end
    if (issue_ready_i && ii >= 0) begin
      e = mq[ii]; e.st = 1; mq[ii] = e;
    end
    for (int k = 0; k < CP; k++) if (commit_ack_i[k]) nack++;
    for (int k = 0; k < nack; k++) e = mq.pop_front();
    m_head = (m_head + nack) % N;
    if (flush_unissued_i) begin
      foreach (mq[j]) if (mq[j].st != 0) keep.push_back(mq[j]);
      mq = keep;
    end else begin
      for (int k = 0; k < DW; k++) begin
        if (dispatch_valid_i[k] && (N - pre) > k) begin
          e.payload = dispatch_payload_i[k*64 +: 64];
          e.data = '0; e.ex = 1'b0; e.st = 0;
          mq.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic drive_idle();
    rst_ni = 1'b1; flush_i = 1'b0; flush_unissued_i = 1'b0;
    dispatch_valid_i = '0; dispatch_payload_i = '0; issue_ready_i = 1'b0;
    wb_valid_i = '0; wb_trans_id_i = '0; wb_data_i = '0; wb_ex_i = '0; commit_ack_i = '0;
  endtask

  task automatic do_reset();
    drive_idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 2; c++) begin
      rst_ni = 1'b0;
      flush_i = 1'($urandom); flush_unissued_i = 1'($urandom);
      dispatch_valid_i = 2'($urandom); dispatch_payload_i = {$urandom, $urandom, $urandom, $urandom};
      issue_ready_i = 1'($urandom); wb_valid_i = 4'($urandom); wb_trans_id_i = 12'($urandom);
      wb_ex_i = 4'($urandom); commit_ack_i = 2'($urandom);
      tick();
    end
    drive_idle();
    n_cmp++; if (count_o !== 4'd0) begin n_err++; $display("FAIL reset_count got=%0d exp=0", count_o); end
    n_cmp++; if (dispatch_ready_o !== 2'b11) begin n_err++; $display("FAIL reset_ready got=%b exp=11", dispatch_ready_o); end
    n_cmp++; if (issue_valid_o !== 1'b0) begin n_err++; $display("FAIL reset_issue_valid got=%b exp=0", issue_valid_o); end
    n_cmp++; if (commit_valid_o !== 2'b00) begin n_err++; $display("FAIL reset_commit_valid got=%b exp=00", commit_valid_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", full_o); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      dispatch_valid_i   = 2'b11;
      dispatch_payload_i = {PBASE + 64'(2*c + 1), PBASE + 64'(2*c)};
      tick();
      n_cmp++; if (count_o !== 4'(2*c + 2)) begin n_err++; $display("FAIL fill_count c=%0d got=%0d exp=%0d", c, count_o, 2*c + 2); end
    end
    dispatch_payload_i = {PBASE + 64'd99, PBASE + 64'd98};
    tick();
    drive_idle();
    n_cmp++; if (full_o !== 1'b1) begin n_err++; $display("FAIL fill_full got=%b exp=1", full_o); end
    n_cmp++; if (count_o !== 4'd8) begin n_err++; $display("FAIL fill_count_full got=%0d exp=8", count_o); end
    n_cmp++; if (dispatch_ready_o !== 2'b00) begin n_err++; $display("FAIL fill_ready got=%b exp=00", dispatch_ready_o); end
    n_cmp++; if (issue_valid_o !== 1'b1 || issue_trans_id_o !== 3'd0 || issue_payload_o !== PBASE)
      begin n_err++; $display("FAIL fill_issue got v=%b id=%0d p=%h exp v=1 id=0 p=%h", issue_valid_o, issue_trans_id_o, issue_payload_o, PBASE); end
  endtask

  task automatic test_ooo_wb();
    do_reset();
    dispatch_valid_i = 2'b11; dispatch_payload_i = {PBASE + 64'h11, PBASE + 64'h10};
    tick();
    drive_idle();
    issue_ready_i = 1'b1;
    n_cmp++; if (issue_valid_o !== 1'b1 || issue_trans_id_o !== 3'd0) begin n_err++; $display("FAIL ooo_issue0 got v=%b id=%0d exp v=1 id=0", issue_valid_o, issue_trans_id_o); end
    tick();
    n_cmp++; if (issue_trans_id_o !== 3'd1 || issue_payload_o !== PBASE + 64'h11) begin n_err++; $display("FAIL ooo_issue1 got id=%0d p=%h exp id=1", issue_trans_id_o, issue_payload_o); end
    tick();
    drive_idle();
    tick();
    wb_valid_i = 4'b0001; wb_trans_id_i = 12'd1; wb_data_i[63:0] = 64'hD1;
    tick();
    drive_idle();
    n_cmp++; if (commit_valid_o !== 2'b00) begin n_err++; $display("FAIL ooo_cv_early got=%b exp=00", commit_valid_o); end
    tick();
    wb_valid_i = 4'b0010; wb_trans_id_i = 12'd0; wb_data_i[127:64] = 64'hD0; wb_ex_i = 4'b0010;
    tick();
    drive_idle();
    n_cmp++; if (commit_valid_o !== 2'b11) begin n_err++; $display("FAIL ooo_cv_both got=%b exp=11", commit_valid_o); end
    n_cmp++; if (commit_payload_o !== {PBASE + 64'h11, PBASE + 64'h10} || commit_data_o !== {64'hD1, 64'hD0} || commit_ex_o !== 2'b01)
      begin n_err++; $display("FAIL ooo_commit_fields got p=%h d=%h ex=%b exp ex=01", commit_payload_o, commit_data_o, commit_ex_o); end
    commit_ack_i = 2'b11;
    tick();
    drive_idle();
    n_cmp++; if (count_o !== 4'd0 || commit_valid_o !== 2'b00) begin n_err++; $display("FAIL ooo_drain got cnt=%0d cv=%b exp cnt=0 cv=00", count_o, commit_valid_o); end
  endtask

  task automatic test_wb_conflict();
    do_reset();
    for (int c = 0; c < 2; c++) begin
      dispatch_valid_i = 2'b11; dispatch_payload_i = {PBASE + 64'(2*c + 1), PBASE + 64'(2*c)};
      tick();
    end
    drive_idle();
    issue_ready_i = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    drive_idle();
    n_cmp++; if (issue_valid_o !== 1'b0) begin n_err++; $display("FAIL conf_all_issued got=%b exp=0", issue_valid_o); end
    wb_valid_i = 4'b0111; wb_trans_id_i = {3'd0, 3'd2, 3'd1, 3'd0};
    wb_data_i = {64'h0, 64'h2, 64'h1, 64'h0};
    tick();
    drive_idle();
    n_cmp++; if (commit_valid_o !== 2'b11) begin n_err++; $display("FAIL conf_cv01 got=%b exp=11", commit_valid_o); end
    commit_ack_i = 2'b11;
    tick();
    drive_idle();
    n_cmp++; if (commit_valid_o !== 2'b01) begin n_err++; $display("FAIL conf_cv2 got=%b exp=01", commit_valid_o); end
    commit_ack_i = 2'b01;
    tick();
    wb_valid_i = 4'b0101; wb_trans_id_i = {3'd0, 3'd3, 3'd0, 3'd3};
    wb_data_i = {64'h0, 64'hB, 64'h0, 64'hA};
    commit_ack_i = 2'b00;
    tick();
    drive_idle();
    n_cmp++; if (commit_valid_o !== 2'b01 || commit_data_o[63:0] !== 64'hA)
      begin n_err++; $display("FAIL conf_lowest_port got cv=%b d=%h exp cv=01 d=a", commit_valid_o, commit_data_o[63:0]); end
  endtask

  task automatic test_flush_unissued();
    do_reset();
    dispatch_valid_i = 2'b11; dispatch_payload_i = {PBASE + 64'h21, PBASE + 64'h20};
    tick();
    dispatch_valid_i = 2'b01; dispatch_payload_i = {64'h0, PBASE + 64'h22};
    tick();
    drive_idle();
    issue_ready_i = 1'b1;
    tick();
    drive_idle();
    flush_unissued_i = 1'b1;
    tick();
    drive_idle();
    n_cmp++; if (count_o !== 4'd1) begin n_err++; $display("FAIL fu_count got=%0d exp=1", count_o); end
    n_cmp++; if (issue_valid_o !== 1'b0) begin n_err++; $display("FAIL fu_issue_valid got=%b exp=0", issue_valid_o); end
    dispatch_valid_i = 2'b01; dispatch_payload_i = {64'h0, PBASE + 64'h30};
    tick();
    drive_idle();
    n_cmp++; if (issue_valid_o !== 1'b1 || issue_trans_id_o !== 3'd1 || issue_payload_o !== PBASE + 64'h30 || count_o !== 4'd2)
      begin n_err++; $display("FAIL fu_redispatch got v=%b id=%0d p=%h cnt=%0d exp v=1 id=1 cnt=2", issue_valid_o, issue_trans_id_o, issue_payload_o, count_o); end
    dispatch_valid_i = 2'b01; dispatch_payload_i = {64'h0, PBASE + 64'h31};
    tick();
    drive_idle();
    flush_unissued_i = 1'b1; issue_ready_i = 1'b1;
    dispatch_valid_i = 2'b11; dispatch_payload_i = {PBASE + 64'h41, PBASE + 64'h40};
    tick();
    drive_idle();
    n_cmp++; if (count_o !== 4'd2 || issue_valid_o !== 1'b0)
      begin n_err++; $display("FAIL fu_with_issue got cnt=%0d v=%b exp cnt=2 v=0", count_o, issue_valid_o); end
  endtask

  task automatic test_wrap();
    int committed, disp_seq, cyc, nc, a, prev_a, nacc;
    int iss[$];
    committed = 0; disp_seq = 0; cyc = 0; prev_a = 0;
    do_reset();
    while (committed < 20 && cyc < 400) begin
      nacc = 0;
      for (int k = 0; k < DW; k++) if ((N - mq.size()) > k) nacc++;
      dispatch_valid_i   = 2'b11;
      dispatch_payload_i = {PBASE + 64'(disp_seq + 1), PBASE + 64'(disp_seq)};
      issue_ready_i      = 1'b1;
      wb_valid_i = '0; wb_trans_id_i = '0; wb_data_i = '0; wb_ex_i = '0;
      iss.delete();
      foreach (mq[j]) if (mq[j].st == 1) iss.push_back(j);
      for (int p = 0; p < WP; p++) begin
        if (p < iss.size()) begin
          wb_valid_i[p] = 1'b1;
          wb_trans_id_i[p*TW +: TW] = 3'((m_head + iss[p]) % N);
          wb_data_i[p*64 +: 64] = mq[iss[p]].payload ^ DMASK;
        end
      end
      nc = m_commit_n();
      a = 0;
      commit_ack_i = 2'b00;
      if (mq.size() == N && nc > 0) begin
        a = $urandom_range(1, nc);
        commit_ack_i = 2'((1 << a) - 1);
        for (int k = 0; k < a; k++) begin
          n_cmp++;
          if (commit_payload_o[k*64 +: 64] !== PBASE + 64'(committed + k) ||
              commit_data_o[k*64 +: 64] !== ((PBASE + 64'(committed + k)) ^ DMASK))
            begin n_err++; $display("FAIL wrap_order seq=%0d got p=%h d=%h", committed + k, commit_payload_o[k*64 +: 64], commit_data_o[k*64 +: 64]); end
        end
      end
      tick();
      cyc++;
      disp_seq += nacc;
      committed += a;
      if (a > 0) begin
        n_cmp++;
        if (count_o !== 4'(N - a) || full_o !== 1'b0 || dispatch_ready_o !== ((a == 2) ? 2'b11 : 2'b01))
          begin n_err++; $display("FAIL wrap_freed a=%0d got cnt=%0d full=%b rdy=%b exp cnt=%0d full=0", a, count_o, full_o, dispatch_ready_o, N - a); end
      end else if (prev_a > 0) begin
        n_cmp++;
        if (count_o !== 4'd8 || full_o !== 1'b1)
          begin n_err++; $display("FAIL wrap_refill got cnt=%0d full=%b exp cnt=8 full=1", count_o, full_o); end
      end else begin
        n_cmp++;
        if (count_o !== 4'(mq.size()) || full_o !== (mq.size() == N))
          begin n_err++; $display("FAIL wrap_count got cnt=%0d full=%b exp cnt=%0d", count_o, full_o, mq.size()); end
      end
      prev_a = a;
    end
    n_cmp++;
    if (committed < 20) begin n_err++; $display("FAIL wrap_timeout got committed=%0d exp >=20", committed); end
    drive_idle();
  endtask

  task automatic test_random();
    int iss[$];
    int a, nc, ii, esz;
    logic [1:0] ecv;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      rst_ni           = ($urandom_range(0, 199) != 0);
      flush_i          = ($urandom_range(0, 99) == 0);
      flush_unissued_i = ($urandom_range(0, 29) == 0);
      a = $urandom_range(0, 2);
      dispatch_valid_i   = (a == 0) ? 2'b00 : (a == 1) ? 2'b01 : 2'b11;
      dispatch_payload_i = {$urandom, $urandom, $urandom, $urandom};
      issue_ready_i      = ($urandom_range(0, 3) != 0);
      wb_valid_i = '0; wb_trans_id_i = '0; wb_ex_i = '0;
      for (int j = 0; j < 8; j++) wb_data_i[j*32 +: 32] = $urandom;
      iss.delete();
      foreach (mq[j]) if (mq[j].st == 1) iss.push_back(j);
      for (int p = 0; p < WP; p++) begin
        if (iss.size() > 0 && $urandom_range(0, 2) != 0) begin
          wb_valid_i[p] = 1'b1;
          wb_trans_id_i[p*TW +: TW] = 3'((m_head + iss[$urandom_range(0, iss.size() - 1)]) % N);
          wb_ex_i[p] = 1'($urandom);
        end
      end
      nc = m_commit_n();
      a = $urandom_range(0, nc);
      commit_ack_i = 2'((1 << a) - 1);
      tick();

      esz = mq.size();
      n_cmp++; if (count_o !== 4'(esz)) begin n_err++; $display("FAIL rnd_count cyc=%0d got=%0d exp=%0d", cyc, count_o, esz); end
      n_cmp++; if (full_o !== (esz == N)) begin n_err++; $display("FAIL rnd_full cyc=%0d got=%b exp=%b", cyc, full_o, esz == N); end
      n_cmp++; if (dispatch_ready_o !== {esz < N - 1, esz < N})
        begin n_err++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b%b", cyc, dispatch_ready_o, esz < N - 1, esz < N); end
      ii = m_issue_idx();
      n_cmp++; if (issue_valid_o !== (ii >= 0)) begin n_err++; $display("FAIL rnd_issue_valid cyc=%0d got=%b exp=%b", cyc, issue_valid_o, ii >= 0); end
      if (ii >= 0) begin
        n_cmp++;
        if (issue_trans_id_o !== 3'((m_head + ii) % N) || issue_payload_o !== mq[ii].payload)
          begin n_err++; $display("FAIL rnd_issue cyc=%0d got id=%0d p=%h exp id=%0d p=%h", cyc, issue_trans_id_o, issue_payload_o, (m_head + ii) % N, mq[ii].payload); end
      end
      nc  = m_commit_n();
      ecv = 2'((1 << nc) - 1);
      n_cmp++; if (commit_valid_o !== ecv) begin n_err++; $display("FAIL rnd_commit_valid cyc=%0d got=%b exp=%b", cyc, commit_valid_o, ecv); end
      for (int k = 0; k < nc; k++) begin
        n_cmp++;
        if (commit_payload_o[k*64 +: 64] !== mq[k].payload || commit_data_o[k*64 +: 64] !== mq[k].data || commit_ex_o[k] !== mq[k].ex)
          begin n_err++; $display("FAIL rnd_commit cyc=%0d port=%0d got p=%h d=%h ex=%b exp p=%h d=%h ex=%b", cyc, k,
            commit_payload_o[k*64 +: 64], commit_data_o[k*64 +: 64], commit_ex_o[k], mq[k].payload, mq[k].data, mq[k].ex); end
      end
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_fill();
    test_ooo_wb();
    test_wb_conflict();
    test_flush_unissued();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
